// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the pipe_stage_buf slice: default payload width,
// default depth, reset payload value and occupancy/pointer width helpers.
package pipe_stage_buf_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int DEF_DEPTH  = 2;
  localparam logic [DATA_WIDTH-1:0] RESET_VALUE = '0;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle around one buffered pipeline stage: upstream push side,
// downstream pop side, stage controls and occupancy.
interface pipe_stage_buf_if
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutData;
  logic             Hold;
  logic             Flush;
  logic [CNT_W-1:0] Count;

  // Environment side: drives offers, consume strobes and controls.
  modport master (
    output InValid, InData, OutReady, Hold, Flush,
    input  InReady, OutValid, OutData, Count
  );

  // Stage side.
  modport slave (
    input  InValid, InData, OutReady, Hold, Flush,
    output InReady, OutValid, OutData, Count
  );

endinterface

// File: rtl/pipe_stage_mem.sv
// Entry storage for pipe_stage_buf: one synchronous write port and one
// asynchronous read port, no reset on the contents.
module pipe_stage_mem
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is combinational so the head entry is visible the cycle after its push.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Buffered pipeline stage: DEPTH-entry FIFO with valid/ready on both sides,
// Hold freeze, Flush discard and a live occupancy count.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(RESET_VALUE)
) (
  input  logic             Clk,
  input  logic             Rst,
  pipe_stage_buf_if.slave  io
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [CNT_W-1:0] w_count_next;

  logic             w_full;
  logic             w_empty;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_data;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Rst gates InReady so the stage never advertises space while held in reset.
  assign w_in_ready  = Rst && !w_full && !io.Hold && !io.Flush;
  assign w_out_valid = !w_empty && !io.Hold;

  assign w_push = io.InValid && w_in_ready;
  assign w_pop  = w_out_valid && io.OutReady && !io.Flush;

  always_comb begin
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    w_count_next = r_count;
    if (io.Flush) begin
      w_head_next  = '0;
      w_tail_next  = '0;
      w_count_next = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (w_push) begin
        w_tail_next = r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        w_head_next = r_head + PTR_W'(1);
      end
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  pipe_stage_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (Clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (io.InData),
    .i_raddr (r_head),
    .o_rdata (w_head_data)
  );

  assign io.InReady  = w_in_ready;
  assign io.OutValid = w_out_valid;
  assign io.OutData  = w_empty ? RESET_DATA : w_head_data;
  assign io.Count    = r_count;

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entry count; power of two, >= 2.
REQ-003 SHALL have parameter RESET_DATA, default 0 (WIDTH bits), value driven on OutData when empty or in reset.
REQ-004 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port InValid  input  1  upstream offers InData.
REQ-007 SHALL have port InReady  output  1  stage accepts InData this cycle.
REQ-008 SHALL have port InData  input  WIDTH  upstream payload.
REQ-009 SHALL have port OutValid  output  1  OutData is a valid entry.
REQ-010 SHALL have port OutReady  input  1  downstream consumes OutData this cycle.
REQ-011 SHALL have port OutData  output  WIDTH  head-entry payload.
REQ-012 SHALL have port Hold  input  1  freeze: no push, no pop.
REQ-013 SHALL have port Flush  input  1  discard all entries.
REQ-014 SHALL have port Count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL push when InValid && InReady; SHALL pop when OutValid && OutReady.
REQ-016 SHALL drive InReady = (Count != DEPTH) && !Hold && !Flush, combinationally.
REQ-017 SHALL drive OutValid = (Count != 0) && !Hold, combinationally.
REQ-018 SHALL drive OutData = head entry when Count != 0, else RESET_DATA; no bypass from InData.
REQ-019 SHALL present a pushed entry on OutData with OutValid=1 exactly one cycle after the push edge (latency 1).
REQ-020 SHALL on simultaneous push and pop update Count unchanged, write at tail, advance head.
REQ-021 SHALL, when full, deassert InReady even if a pop occurs in the same cycle (no full-pass-through).
REQ-022 SHALL wrap head/tail pointers modulo DEPTH; order strictly FIFO.
REQ-023 SHALL on Flush=1 set Count=0 and head=tail=0 at the next edge; Flush overrides Hold, push and pop.
REQ-024 SHALL on Hold=1 (Flush=0) keep pointers, Count and storage unchanged.
REQ-025 SHALL ignore InValid when InReady=0 and ignore OutReady when OutValid=0.
REQ-026 SHALL not require InData to be stable beyond the push edge.

Reset
REQ-027 SHALL on Rst=0, asynchronously: Count=0, pointers=0, OutValid=0, InReady=0, OutData=RESET_DATA.
REQ-028 SHALL discard in-flight entries when reset asserts mid-operation; storage contents need not clear.
REQ-029 SHALL assert InReady=1 in the first cycle after Rst deasserts (Hold=0, Flush=0).

Structure
REQ-030 SHALL take DataWidth and reset-value constants from the shared defines header; no block-local duplicates.
REQ-031 SHALL isolate the storage array in one sub-module, pipe_stage_mem (write port, async read port, no reset).
REQ-032 SHALL contain pointer/count control in pipe_stage_buf only; total RTL 120-400 lines.

Verification
REQ-033 SHALL cover: reset, push 0xA5 with OutReady=0 -> next cycle OutValid=1, OutData=0xA5, Count=1.
REQ-034 SHALL cover: DEPTH=2, push 0x1,0x2 with OutReady=0 -> InReady=0, Count=2; then OutReady=1 -> 0x1 then 0x2, Count returns 0, OutData=RESET_DATA.
REQ-035 SHALL cover: Count=1, push 0x3 and pop same cycle -> Count stays 1, OutData=0x3 next cycle.
REQ-036 SHALL cover: Count=2, Flush=1 with Hold=1 and InValid=1 -> next cycle Count=0, OutValid=0, no entry written.
REQ-037 SHALL cover: Count=1, Hold=1 for 3 cycles with InValid=1, OutReady=1 -> Count=1, OutData unchanged, no handshakes.
REQ-038 SHALL cover: DEPTH=4, 10 random-stall transfers 0x0..0x9 -> output order 0x0..0x9 across pointer wrap; Rst=0 mid-stream -> Count=0 immediately.
